wb_trap_seq: RTL and testbench

- Parametrised successor to the writeback/trap stage.
- Retires the instruction in WB: writes GPR and CSR results and counts retired instructions (minstret).
- Sequences traps through a registered state machine: capture, flush handshake, redirect. Also handles mret.
- Adds spec-ordered interrupt priority, optional vectored mtvec, precise interrupt mepc and a WB ready/valid handshake.
- Sits between MEM/WB pipeline register, regfile, CSR file and pipeline controller.

---
 rtl/wb_trap_pkg.sv | 57 +++++
 rtl/wb_trap_seq_cause_enc.sv | 49 ++++
 rtl/wb_trap_seq.sv | 205 ++++++++++++++++++++
 tb/tb_wb_trap_seq.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_trap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_trap_pkg
// Description : Shared types and constants for the writeback/trap sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } wb_state_e;

    localparam int unsigned c_CODE_W = 6;

    localparam logic [c_CODE_W-1:0] c_EXC_IADDR_MISALIGN = 6'd0;
    localparam logic [c_CODE_W-1:0] c_EXC_IACCESS        = 6'd1;
    localparam logic [c_CODE_W-1:0] c_EXC_ILLEGAL        = 6'd2;
    localparam logic [c_CODE_W-1:0] c_EXC_BREAKPOINT     = 6'd3;
    localparam logic [c_CODE_W-1:0] c_EXC_LOAD_MISALIGN  = 6'd4;
    localparam logic [c_CODE_W-1:0] c_EXC_LOAD_ACCESS    = 6'd5;
    localparam logic [c_CODE_W-1:0] c_EXC_STORE_MISALIGN = 6'd6;
    localparam logic [c_CODE_W-1:0] c_EXC_STORE_ACCESS   = 6'd7;
    localparam logic [c_CODE_W-1:0] c_EXC_ECALL_M        = 6'd11;

    localparam logic [c_CODE_W-1:0] c_IRQ_MSI = 6'd3;
    localparam logic [c_CODE_W-1:0] c_IRQ_MTI = 6'd7;
    localparam logic [c_CODE_W-1:0] c_IRQ_MEI = 6'd11;

    // Bit positions inside the {MEI,MTI,MSI} pending/enable vectors
    localparam int unsigned c_IRQ_BIT_MSI = 0;
    localparam int unsigned c_IRQ_BIT_MTI = 1;
    localparam int unsigned c_IRQ_BIT_MEI = 2;

    // Ranked exception codes, element 0 is the highest priority
    localparam int unsigned c_N_RANKED = 9;
    localparam logic [c_N_RANKED-1:0][c_CODE_W-1:0] c_EXCP_PRIO = {
        c_EXC_STORE_ACCESS, c_EXC_LOAD_ACCESS, c_EXC_STORE_MISALIGN,
        c_EXC_LOAD_MISALIGN, c_EXC_ECALL_M, c_EXC_BREAKPOINT,
        c_EXC_IADDR_MISALIGN, c_EXC_ILLEGAL, c_EXC_IACCESS
    };

    // Smaller rank wins; unranked codes follow the table, highest code first
    function automatic int rank_of(input logic [c_CODE_W-1:0] code);
        int r;
        r = int'(c_N_RANKED) + (63 - int'(code));
        for (int k = 0; k < int'(c_N_RANKED); k++) begin
            if (c_EXCP_PRIO[k] == code) begin
                r = k;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_trap_seq_cause_enc.sv
`default_nettype none
// ============================================================================
// Module      : trap_cause_enc
// Description : Combinational priority encoder selecting the trap cause from
//               masked interrupts and exception requests.
// Revision    : 1.0 - initial release
// ============================================================================
module trap_cause_enc
    import wb_trap_pkg::*;
#(
    parameter int EXCP_W = 16
) (
    input  logic [EXCP_W-1:0]   i_excp,
    input  logic [2:0]          i_irq,
    output logic                o_taken,
    output logic                o_is_int,
    output logic [c_CODE_W-1:0] o_code
);

    int w_best;

    always_comb begin
        o_taken  = 1'b0;
        o_is_int = 1'b0;
        o_code   = '0;
        w_best   = 32'h7fff_ffff;
        if (|i_irq) begin
            o_taken  = 1'b1;
            o_is_int = 1'b1;
            if (i_irq[c_IRQ_BIT_MEI]) begin
                o_code = c_IRQ_MEI;
            end else if (i_irq[c_IRQ_BIT_MSI]) begin
                o_code = c_IRQ_MSI;
            end else begin
                o_code = c_IRQ_MTI;
            end
        end else if (|i_excp) begin
            o_taken = 1'b1;
            for (int i = 0; i < EXCP_W; i++) begin
                if (i_excp[i] && (rank_of(c_CODE_W'(i)) < w_best)) begin
                    w_best = rank_of(c_CODE_W'(i));
                    o_code = c_CODE_W'(i);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_trap_seq.sv
`default_nettype none
// ============================================================================
// Module      : wb_trap_seq
// Description : Writeback retirement and trap/mret sequencer (capture, flush
//               handshake, redirect). Optional macro WB_VECTORED_INT_EN
//               enables vectored mtvec for interrupts.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_trap_seq
    import wb_trap_pkg::*;
#(
    parameter int              XLEN   = 64,
    parameter int              EXCP_W = 16,
    parameter logic [XLEN-1:0] PC_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid_i,
    output logic              wb_ready_o,
    input  logic [XLEN-1:0]   wb_pc_i,
    input  logic [31:0]       wb_instr_i,
    input  logic              wb_is_load_i,
    input  logic              wb_is_csr_i,
    input  logic              wb_rd_wen_i,
    input  logic [4:0]        wb_rd_idx_i,
    input  logic [XLEN-1:0]   wb_alu_res_i,
    input  logic [XLEN-1:0]   wb_mem_rdata_i,
    input  logic [XLEN-1:0]   wb_csr_rdata_i,
    input  logic              wb_csr_wen_i,
    input  logic [11:0]       wb_csr_idx_i,
    input  logic [XLEN-1:0]   wb_csr_wdata_i,
    input  logic [EXCP_W-1:0] wb_excp_i,
    input  logic              wb_mret_i,
    input  logic              mstatus_mie_i,
    input  logic [2:0]        irq_pend_i,
    input  logic [2:0]        irq_en_i,
    input  logic [XLEN-1:0]   mtvec_i,
    input  logic [XLEN-1:0]   mepc_i,
    output logic              rd_wen_o,
    output logic [4:0]        rd_idx_o,
    output logic [XLEN-1:0]   rd_wdata_o,
    output logic              csr_wen_o,
    output logic [11:0]       csr_idx_o,
    output logic [XLEN-1:0]   csr_wdata_o,
    output logic              mcause_wen_o,
    output logic [XLEN-1:0]   mcause_wdata_o,
    output logic              mepc_wen_o,
    output logic [XLEN-1:0]   mepc_wdata_o,
    output logic              mtval_wen_o,
    output logic [XLEN-1:0]   mtval_wdata_o,
    output logic              mie_clear_o,
    output logic              mie_restore_o,
    output logic              flush_req_o,
    input  logic              flush_ack_i,
    output logic              redirect_valid_o,
    output logic [XLEN-1:0]   redirect_pc_o,
    output logic [XLEN-1:0]   minstret_o
);

    wb_state_e              r_state;
    wb_state_e              w_state_nxt;

    logic                   w_accept;
    logic                   w_trap;
    logic                   w_retire;
    logic                   w_mret_go;
    logic [2:0]             w_irq_live;
    logic                   w_enc_taken;
    logic                   w_enc_is_int;
    logic [c_CODE_W-1:0]    w_enc_code;
    logic [XLEN-1:0]        w_mtval;
    logic [XLEN-1:0]        w_base;
    logic [XLEN-1:0]        w_trap_target;
    logic [XLEN-1:0]        w_mcause;

    logic                   r_pulse;
    logic                   r_is_trap;
    logic                   r_is_int;
    logic [c_CODE_W-1:0]    r_code;
    logic [XLEN-1:0]        r_mepc;
    logic [XLEN-1:0]        r_mtval;
    logic [XLEN-1:0]        r_target;
    logic [XLEN-1:0]        r_minstret;

    assign w_irq_live = irq_pend_i & irq_en_i & {3{mstatus_mie_i}};

    trap_cause_enc #(
        .EXCP_W (EXCP_W)
    ) u_cause_enc (
        .i_excp   (wb_excp_i),
        .i_irq    (w_irq_live),
        .o_taken  (w_enc_taken),
        .o_is_int (w_enc_is_int),
        .o_code   (w_enc_code)
    );

    assign w_accept  = wb_valid_i && wb_ready_o && !rst;
    assign w_trap    = w_accept && w_enc_taken;
    assign w_retire  = w_accept && !w_enc_taken;
    assign w_mret_go = w_retire && wb_mret_i;

    // Retirement writes go straight out in the accept cycle
    assign rd_wen_o    = w_retire && wb_rd_wen_i;
    assign rd_idx_o    = wb_rd_idx_i;
    assign rd_wdata_o  = wb_is_load_i ? wb_mem_rdata_i :
                         wb_is_csr_i  ? wb_csr_rdata_i : wb_alu_res_i;
    assign csr_wen_o   = w_retire && wb_csr_wen_i;
    assign csr_idx_o   = wb_csr_idx_i;
    assign csr_wdata_o = wb_csr_wdata_i;

    always_comb begin
        w_mtval = '0;
        if (!w_enc_is_int) begin
            if ((w_enc_code == c_EXC_IADDR_MISALIGN) || (w_enc_code == c_EXC_IACCESS)) begin
                w_mtval = wb_pc_i;
            end else if (w_enc_code == c_EXC_ILLEGAL) begin
                w_mtval = XLEN'(wb_instr_i);
            end else if ((w_enc_code >= c_EXC_LOAD_MISALIGN) && (w_enc_code <= c_EXC_STORE_ACCESS)) begin
                w_mtval = wb_alu_res_i;
            end
        end
    end

    assign w_base = mtvec_i & ~XLEN'(3);

`ifdef WB_VECTORED_INT_EN
    assign w_trap_target = (w_enc_is_int && (mtvec_i[1:0] == 2'b01)) ?
                           (w_base + (XLEN'(w_enc_code) << 2)) : w_base;
`else
    assign w_trap_target = w_base;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (w_trap || w_mret_go) w_state_nxt = ST_FLUSH;
            ST_FLUSH:    if (flush_ack_i) w_state_nxt = ST_REDIRECT;
            ST_REDIRECT: w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wb_ready_o       = (r_state == ST_IDLE);
        flush_req_o      = (r_state == ST_FLUSH);
        redirect_valid_o = (r_state == ST_REDIRECT);
    end

    // Cause/target capture; r_pulse marks the first FLUSH cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pulse    <= 1'b0;
            r_is_trap  <= 1'b0;
            r_is_int   <= 1'b0;
            r_code     <= '0;
            r_mepc     <= '0;
            r_mtval    <= '0;
            r_target   <= PC_RST;
            r_minstret <= '0;
        end else begin
            r_pulse <= w_trap || w_mret_go;
            if (w_trap) begin
                r_is_trap <= 1'b1;
                r_is_int  <= w_enc_is_int;
                r_code    <= w_enc_code;
                r_mepc    <= wb_pc_i;
                r_mtval   <= w_mtval;
                r_target  <= w_trap_target;
            end else if (w_mret_go) begin
                r_is_trap <= 1'b0;
                r_target  <= mepc_i;
            end
            if (w_retire) begin
                r_minstret <= r_minstret + XLEN'(1);
            end
        end
    end

    always_comb begin
        w_mcause                = '0;
        w_mcause[c_CODE_W-1:0]  = r_code;
        w_mcause[XLEN-1]        = r_is_int;
    end

    assign mcause_wen_o   = r_pulse && r_is_trap;
    assign mepc_wen_o     = r_pulse && r_is_trap;
    assign mtval_wen_o    = r_pulse && r_is_trap;
    assign mie_clear_o    = r_pulse && r_is_trap;
    assign mie_restore_o  = r_pulse && !r_is_trap;
    assign mcause_wdata_o = w_mcause;
    assign mepc_wdata_o   = r_mepc;
    assign mtval_wdata_o  = r_mtval;
    assign redirect_pc_o  = r_target;
    assign minstret_o     = r_minstret;

endmodule
`default_nettype wire

// File: tb/tb_wb_trap_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_trap_seq
// Description : Self-checking bench for wb_trap_seq (64-bit instance plus an
//               8-bit instance for minstret wrap). Honours WB_VECTORED_INT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_trap_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wb_valid_i, wb_ready_o;
    logic [63:0] wb_pc_i;
    logic [31:0] wb_instr_i;
    logic        wb_is_load_i, wb_is_csr_i, wb_rd_wen_i;
    logic [4:0]  wb_rd_idx_i;
    logic [63:0] wb_alu_res_i, wb_mem_rdata_i, wb_csr_rdata_i;
    logic        wb_csr_wen_i;
    logic [11:0] wb_csr_idx_i;
    logic [63:0] wb_csr_wdata_i;
    logic [15:0] wb_excp_i;
    logic        wb_mret_i, mstatus_mie_i;
    logic [2:0]  irq_pend_i, irq_en_i;
    logic [63:0] mtvec_i, mepc_i;
    logic        rd_wen_o;
    logic [4:0]  rd_idx_o;
    logic [63:0] rd_wdata_o;
    logic        csr_wen_o;
    logic [11:0] csr_idx_o;
    logic [63:0] csr_wdata_o;
    logic        mcause_wen_o, mepc_wen_o, mtval_wen_o;
    logic [63:0] mcause_wdata_o, mepc_wdata_o, mtval_wdata_o;
    logic        mie_clear_o, mie_restore_o, flush_req_o, flush_ack_i;
    logic        redirect_valid_o;
    logic [63:0] redirect_pc_o, minstret_o;

    wb_trap_seq #(.XLEN(64), .EXCP_W(16), .PC_RST(64'h0)) u_dut (
        .clk(clk), .rst(rst),
        .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
        .wb_pc_i(wb_pc_i), .wb_instr_i(wb_instr_i),
        .wb_is_load_i(wb_is_load_i), .wb_is_csr_i(wb_is_csr_i),
        .wb_rd_wen_i(wb_rd_wen_i), .wb_rd_idx_i(wb_rd_idx_i),
        .wb_alu_res_i(wb_alu_res_i), .wb_mem_rdata_i(wb_mem_rdata_i),
        .wb_csr_rdata_i(wb_csr_rdata_i),
        .wb_csr_wen_i(wb_csr_wen_i), .wb_csr_idx_i(wb_csr_idx_i),
        .wb_csr_wdata_i(wb_csr_wdata_i),
        .wb_excp_i(wb_excp_i), .wb_mret_i(wb_mret_i),
        .mstatus_mie_i(mstatus_mie_i), .irq_pend_i(irq_pend_i), .irq_en_i(irq_en_i),
        .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .rd_wen_o(rd_wen_o), .rd_idx_o(rd_idx_o), .rd_wdata_o(rd_wdata_o),
        .csr_wen_o(csr_wen_o), .csr_idx_o(csr_idx_o), .csr_wdata_o(csr_wdata_o),
        .mcause_wen_o(mcause_wen_o), .mcause_wdata_o(mcause_wdata_o),
        .mepc_wen_o(mepc_wen_o), .mepc_wdata_o(mepc_wdata_o),
        .mtval_wen_o(mtval_wen_o), .mtval_wdata_o(mtval_wdata_o),
        .mie_clear_o(mie_clear_o), .mie_restore_o(mie_restore_o),
        .flush_req_o(flush_req_o), .flush_ack_i(flush_ack_i),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .minstret_o(minstret_o)
    );

    // Narrow instance used only to reach the minstret wrap point quickly
    logic        d8_valid, d8_ready, d8_rd_wen, d8_csr_wen;
    logic [4:0]  d8_rd_idx;
    logic [11:0] d8_csr_idx;
    logic [7:0]  d8_rd_wdata, d8_csr_wdata, d8_mcause, d8_mepc, d8_mtval, d8_rpc, d8_minstret;
    logic        d8_mcause_wen, d8_mepc_wen, d8_mtval_wen, d8_mie_clr, d8_mie_rst, d8_flush, d8_rvalid;

    wb_trap_seq #(.XLEN(8), .EXCP_W(16), .PC_RST(8'h0)) u_dut8 (
        .clk(clk), .rst(rst),
        .wb_valid_i(d8_valid), .wb_ready_o(d8_ready),
        .wb_pc_i(8'h10), .wb_instr_i(32'h13),
        .wb_is_load_i(1'b0), .wb_is_csr_i(1'b0),
        .wb_rd_wen_i(1'b1), .wb_rd_idx_i(5'd1),
        .wb_alu_res_i(8'h3), .wb_mem_rdata_i(8'h0), .wb_csr_rdata_i(8'h0),
        .wb_csr_wen_i(1'b0), .wb_csr_idx_i(12'h0), .wb_csr_wdata_i(8'h0),
        .wb_excp_i(16'h0), .wb_mret_i(1'b0),
        .mstatus_mie_i(1'b0), .irq_pend_i(3'b000), .irq_en_i(3'b000),
        .mtvec_i(8'h80), .mepc_i(8'h0),
        .rd_wen_o(d8_rd_wen), .rd_idx_o(d8_rd_idx), .rd_wdata_o(d8_rd_wdata),
        .csr_wen_o(d8_csr_wen), .csr_idx_o(d8_csr_idx), .csr_wdata_o(d8_csr_wdata),
        .mcause_wen_o(d8_mcause_wen), .mcause_wdata_o(d8_mcause),
        .mepc_wen_o(d8_mepc_wen), .mepc_wdata_o(d8_mepc),
        .mtval_wen_o(d8_mtval_wen), .mtval_wdata_o(d8_mtval),
        .mie_clear_o(d8_mie_clr), .mie_restore_o(d8_mie_rst),
        .flush_req_o(d8_flush), .flush_ack_i(1'b0),
        .redirect_valid_o(d8_rvalid), .redirect_pc_o(d8_rpc),
        .minstret_o(d8_minstret)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Returns -1 for no trap, code for an exception, 64+code for an interrupt.
    function automatic int model_cause(input logic [15:0] ex, input logic [2:0] irq);
        int order [9];
        order = '{1, 2, 0, 3, 11, 4, 6, 5, 7};
        if (irq[2]) return 64 + 11;
        if (irq[0]) return 64 + 3;
        if (irq[1]) return 64 + 7;
        for (int k = 0; k < 9; k++) if (ex[order[k]]) return order[k];
        for (int i = 15; i >= 0; i--) if (ex[i]) return i;
        return -1;
    endfunction

    int          m_phase;   // 0 accepting, 1 waiting for flush ack, 2 redirecting
    logic        m_pulse, m_is_trap;
    logic [63:0] m_cause, m_mepc, m_mtval, m_target, m_minstret;
    logic        m_accept, m_taken, m_int;
    int          m_c, m_code;
    logic [63:0] m_cause_nxt, m_mtval_nxt, m_target_nxt;

    always_comb begin
        m_accept    = wb_valid_i && (m_phase == 0) && !rst;
        m_c         = model_cause(wb_excp_i, irq_pend_i & irq_en_i & {3{mstatus_mie_i}});
        m_taken     = m_accept && (m_c >= 0);
        m_int       = (m_c >= 64);
        m_code      = m_int ? (m_c - 64) : m_c;
        m_cause_nxt = (m_int ? 64'h8000_0000_0000_0000 : 64'h0) | 64'(m_code);
        m_mtval_nxt = 64'h0;
        if (!m_int) begin
            if (m_code == 0 || m_code == 1)      m_mtval_nxt = wb_pc_i;
            else if (m_code == 2)                m_mtval_nxt = {32'h0, wb_instr_i};
            else if (m_code >= 4 && m_code <= 7) m_mtval_nxt = wb_alu_res_i;
        end
        m_target_nxt = {mtvec_i[63:2], 2'b00};
`ifdef WB_VECTORED_INT_EN
        if (m_int && mtvec_i[1:0] == 2'b01) m_target_nxt = m_target_nxt + 64'(4 * m_code);
`endif
    end

    always @(posedge clk) begin
        if (rst) begin
            m_phase    <= 0;
            m_pulse    <= 1'b0;
            m_is_trap  <= 1'b0;
            m_minstret <= 64'h0;
        end else begin
            m_pulse <= 1'b0;
            if (m_phase == 0) begin
                if (m_taken) begin
                    m_phase   <= 1;
                    m_pulse   <= 1'b1;
                    m_is_trap <= 1'b1;
                    m_cause   <= m_cause_nxt;
                    m_mepc    <= wb_pc_i;
                    m_mtval   <= m_mtval_nxt;
                    m_target  <= m_target_nxt;
                end else if (m_accept) begin
                    m_minstret <= m_minstret + 64'h1;
                    if (wb_mret_i) begin
                        m_phase   <= 1;
                        m_pulse   <= 1'b1;
                        m_is_trap <= 1'b0;
                        m_target  <= mepc_i;
                    end
                end
            end else if (m_phase == 1) begin
                if (flush_ack_i) m_phase <= 2;
            end else begin
                m_phase <= 0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("m.wb_ready", wb_ready_o, m_phase == 0);
            check("m.rd_wen", rd_wen_o, m_accept && !m_taken && wb_rd_wen_i);
            if (m_accept && !m_taken && wb_rd_wen_i) begin
                check("m.rd_idx", rd_idx_o, wb_rd_idx_i);
                check("m.rd_wdata", rd_wdata_o, wb_is_load_i ? wb_mem_rdata_i :
                                                wb_is_csr_i ? wb_csr_rdata_i : wb_alu_res_i);
            end
            check("m.csr_wen", csr_wen_o, m_accept && !m_taken && wb_csr_wen_i);
            if (m_accept && !m_taken && wb_csr_wen_i) begin
                check("m.csr_idx", csr_idx_o, wb_csr_idx_i);
                check("m.csr_wdata", csr_wdata_o, wb_csr_wdata_i);
            end
            check("m.mcause_wen", mcause_wen_o, m_pulse && m_is_trap);
            check("m.mepc_wen", mepc_wen_o, m_pulse && m_is_trap);
            check("m.mtval_wen", mtval_wen_o, m_pulse && m_is_trap);
            check("m.mie_clear", mie_clear_o, m_pulse && m_is_trap);
            check("m.mie_restore", mie_restore_o, m_pulse && !m_is_trap);
            if (m_pulse && m_is_trap) begin
                check("m.mcause", mcause_wdata_o, m_cause);
                check("m.mepc", mepc_wdata_o, m_mepc);
                check("m.mtval", mtval_wdata_o, m_mtval);
            end
            check("m.flush_req", flush_req_o, m_phase == 1);
            check("m.redirect_valid", redirect_valid_o, m_phase == 2);
            if (m_phase == 2) check("m.redirect_pc", redirect_pc_o, m_target);
            check("m.minstret", minstret_o, m_minstret);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wb_valid_i = 0; wb_pc_i = 0; wb_instr_i = 0;
        wb_is_load_i = 0; wb_is_csr_i = 0; wb_rd_wen_i = 0; wb_rd_idx_i = 0;
        wb_alu_res_i = 0; wb_mem_rdata_i = 0; wb_csr_rdata_i = 0;
        wb_csr_wen_i = 0; wb_csr_idx_i = 0; wb_csr_wdata_i = 0;
        wb_excp_i = 0; wb_mret_i = 0; mstatus_mie_i = 0;
        irq_pend_i = 0; irq_en_i = 0; mtvec_i = 64'h8000; mepc_i = 0;
        flush_ack_i = 0;
    endtask

    task automatic run_trap(input string nm, input logic [63:0] pc, input logic [31:0] instr,
                            input logic [15:0] ex, input logic [2:0] pend, input logic [63:0] mtvec,
                            input logic [63:0] alu, input logic [63:0] exp_cause,
                            input logic [63:0] exp_mtval, input logic [63:0] exp_target);
        wb_valid_i = 1; wb_pc_i = pc; wb_instr_i = instr; wb_excp_i = ex;
        irq_pend_i = pend; irq_en_i = 3'b111; mstatus_mie_i = 1; mtvec_i = mtvec;
        wb_alu_res_i = alu; wb_rd_wen_i = 1; wb_rd_idx_i = 5'd9;
        @(negedge clk);
        check({nm, ".no_rd_wen"}, rd_wen_o, 0);
        step();
        clear_inputs();
        @(negedge clk);
        check({nm, ".mcause_wen"}, mcause_wen_o, 1);
        check({nm, ".mcause"}, mcause_wdata_o, exp_cause);
        check({nm, ".mepc"}, mepc_wdata_o, pc);
        check({nm, ".mtval"}, mtval_wdata_o, exp_mtval);
        check({nm, ".mie_clear"}, mie_clear_o, 1);
        flush_ack_i = 1;
        step();
        flush_ack_i = 0;
        @(negedge clk);
        check({nm, ".redirect_valid"}, redirect_valid_o, 1);
        check({nm, ".redirect_pc"}, redirect_pc_o, exp_target);
        step();
    endtask

    initial begin
        clear_inputs();
        d8_valid = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk_en = 1'b1;

        @(negedge clk);
        check("rst.wb_ready", wb_ready_o, 1);
        check("rst.redirect_pc", redirect_pc_o, 64'h0);
        check("rst.redirect_valid", redirect_valid_o, 0);
        check("rst.flush_req", flush_req_o, 0);
        check("rst.mcause_wen", mcause_wen_o, 0);
        check("rst.minstret", minstret_o, 0);

        // Retire: ALU, CSR, load, then an instruction with interrupts globally masked
        step();
        wb_valid_i = 1; wb_pc_i = 64'h100; wb_rd_wen_i = 1; wb_rd_idx_i = 5'd5; wb_alu_res_i = 64'h2A;
        @(negedge clk);
        check("alu.rd_wen", rd_wen_o, 1);
        check("alu.rd_wdata", rd_wdata_o, 64'h2A);
        check("alu.minstret_before", minstret_o, 0);
        step();
        wb_is_csr_i = 1; wb_csr_rdata_i = 64'h77; wb_csr_wen_i = 1;
        wb_csr_idx_i = 12'h340; wb_csr_wdata_i = 64'h55;
        @(negedge clk);
        check("alu.minstret_after", minstret_o, 1);
        check("csr.rd_wdata", rd_wdata_o, 64'h77);
        check("csr.csr_wen", csr_wen_o, 1);
        step();
        wb_is_csr_i = 0; wb_csr_wen_i = 0; wb_is_load_i = 1; wb_mem_rdata_i = 64'h99;
        @(negedge clk);
        check("load.rd_wdata", rd_wdata_o, 64'h99);
        step();
        clear_inputs();
        wb_valid_i = 1; wb_rd_wen_i = 1; wb_alu_res_i = 64'h5;
        irq_pend_i = 3'b111; irq_en_i = 3'b111; mstatus_mie_i = 0;
        @(negedge clk);
        check("mie_off.rd_wen", rd_wen_o, 1);
        step();
        clear_inputs();
        @(negedge clk);
        check("retire.minstret", minstret_o, 4);

        // Illegal instruction with a 3-cycle flush wait; WB valid during flush is ignored
        step();
        wb_valid_i = 1; wb_pc_i = 64'h200; wb_instr_i = 32'hFFFF_FFFF; wb_excp_i = 16'h0004;
        wb_rd_wen_i = 1; wb_alu_res_i = 64'h11;
        @(negedge clk);
        check("ill.no_rd_wen", rd_wen_o, 0);
        step();
        wb_excp_i = 0;
        @(negedge clk);
        check("ill.mcause", mcause_wdata_o, 64'h2);
        check("ill.mepc", mepc_wdata_o, 64'h200);
        check("ill.mtval", mtval_wdata_o, 64'hFFFF_FFFF);
        check("ill.mie_clear", mie_clear_o, 1);
        check("ill.flush_valid_ignored", rd_wen_o, 0);
        step();
        @(negedge clk);
        check("ill.pulse_once", mcause_wen_o, 0);
        step();
        flush_ack_i = 1;
        @(negedge clk);
        check("ill.flush_req", flush_req_o, 1);
        step();
        clear_inputs();
        @(negedge clk);
        check("ill.redirect_valid", redirect_valid_o, 1);
        check("ill.redirect_pc", redirect_pc_o, 64'h8000);
        step();
        @(negedge clk);
        check("ill.redirect_once", redirect_valid_o, 0);
        check("ill.minstret", minstret_o, 4);
        step();

        // Interrupt priority and exception ordering
`ifdef WB_VECTORED_INT_EN
        run_trap("mei", 64'h300, 32'h73, 16'h0800, 3'b110, 64'h8001, 64'h0,
                 64'h8000_0000_0000_000B, 64'h0, 64'h802C);
        run_trap("msi", 64'h310, 32'h13, 16'h0000, 3'b011, 64'h8001, 64'h0,
                 64'h8000_0000_0000_0003, 64'h0, 64'h800C);
`else
        run_trap("mei", 64'h300, 32'h73, 16'h0800, 3'b110, 64'h8001, 64'h0,
                 64'h8000_0000_0000_000B, 64'h0, 64'h8000);
        run_trap("msi", 64'h310, 32'h13, 16'h0000, 3'b011, 64'h8001, 64'h0,
                 64'h8000_0000_0000_0003, 64'h0, 64'h8000);
`endif
        run_trap("mti", 64'h320, 32'h13, 16'h0000, 3'b010, 64'h8000, 64'h0,
                 64'h8000_0000_0000_0007, 64'h0, 64'h8000);
        run_trap("iacc", 64'h600, 32'h13, 16'h0003, 3'b000, 64'h8001, 64'h0,
                 64'h1, 64'h600, 64'h8000);
        run_trap("ldmis", 64'h610, 32'h13, 16'h0050, 3'b000, 64'h8000, 64'hABC,
                 64'h4, 64'hABC, 64'h8000);
        run_trap("ldacc", 64'h620, 32'h13, 16'h00A0, 3'b000, 64'h8000, 64'hDEF,
                 64'h5, 64'hDEF, 64'h8000);
        run_trap("unrank", 64'h630, 32'h13, 16'hA100, 3'b000, 64'h8000, 64'h1,
                 64'hF, 64'h0, 64'h8000);

        // mret: target is mepc_i sampled in the accept cycle
        wb_valid_i = 1; wb_pc_i = 64'h400; wb_mret_i = 1; mepc_i = 64'h440;
        @(negedge clk);
        check("mret.no_rd_wen", rd_wen_o, 0);
        step();
        clear_inputs();
        mepc_i = 64'h999;
        @(negedge clk);
        check("mret.mie_restore", mie_restore_o, 1);
        check("mret.no_mcause", mcause_wen_o, 0);
        check("mret.minstret", minstret_o, 5);
        flush_ack_i = 1;
        step();
        flush_ack_i = 0;
        @(negedge clk);
        check("mret.redirect_pc", redirect_pc_o, 64'h440);
        check("mret.redirect_valid", redirect_valid_o, 1);
        step();

        // Reset while flushing abandons the trap
        wb_valid_i = 1; wb_pc_i = 64'h500; wb_excp_i = 16'h0008;
        step();
        clear_inputs();
        @(negedge clk);
        check("rstflush.flush_req", flush_req_o, 1);
        step();
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        check("rstflush.wb_ready", wb_ready_o, 1);
        check("rstflush.flush_req", flush_req_o, 0);
        check("rstflush.redirect_valid", redirect_valid_o, 0);
        check("rstflush.minstret", minstret_o, 0);
        step();
        @(negedge clk);
        check("rstflush.no_redirect", redirect_valid_o, 0);

        // 8-bit minstret wraps from all-ones to zero
        step();
        d8_valid = 1;
        repeat (255) step();
        @(negedge clk);
        check("w8.rd_wen", d8_rd_wen, 1);
        check("w8.minstret_ones", d8_minstret, 8'hFF);
        step();
        @(negedge clk);
        check("w8.minstret_wrap", d8_minstret, 8'h00);
        d8_valid = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
